// File: rtl/decoder_2_7.sv
// Receive-side decoder for the 2-to-7 FNS CAC TSV code: masks dead TSVs, sums the
// weighted code bits in two pipeline stages and flags overflow / masked-bit hits.

module decoder_2_7_term #(
  parameter int FNS_W = 8
) (
  input  logic             bit_in,
  input  logic             en,
  input  logic [FNS_W-1:0] weight,
  output logic [FNS_W-1:0] term,
  output logic             viol
);
  assign term = (bit_in & en) ? weight : '0;
  assign viol = bit_in & ~en;
endmodule

module decoder_2_7 #(
  parameter int CODE_W = 9,
  parameter int DATA_W = 7,
  parameter int FNS_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [CODE_W-1:0] en_flag,
  input  logic              FNS02,
  input  logic [FNS_W-1:0]  FNS03,
  input  logic [FNS_W-1:0]  FNS04,
  input  logic [FNS_W-1:0]  FNS05,
  input  logic [FNS_W-1:0]  FNS06,
  input  logic [FNS_W-1:0]  FNS07,
  input  logic [FNS_W-1:0]  FNS08,
  input  logic [FNS_W-1:0]  FNS09,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] codein,
  output logic              data_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              ovf,
  output logic              mask_err,
  output logic [7:0]        err_count
);
  localparam int PS_W  = FNS_W + 3;
  localparam int SUM_W = FNS_W + 4;
  localparam int LO_N  = 5;
  localparam logic [SUM_W-1:0] MAX_VAL = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic [CODE_W-1:1][FNS_W-1:0] FIB_W = {
    FNS_W'(34), FNS_W'(21), FNS_W'(13), FNS_W'(8),
    FNS_W'(5),  FNS_W'(3),  FNS_W'(2),  FNS_W'(1)};

  logic [CODE_W-1:0]             en_sh;
  logic [CODE_W-1:1][FNS_W-1:0]  w_sh;
  logic [CODE_W-1:1][FNS_W-1:0]  cfg_w;
  logic [CODE_W-1:0][FNS_W-1:0]  wvec;
  logic [CODE_W-1:0][FNS_W-1:0]  terms;
  logic [CODE_W-1:0]             viol;
  logic [PS_W-1:0]               lo_n, hi_n, psum_lo, psum_hi;
  logic                          merr1;
  logic [1:0]                    vld_pipe;
  logic [SUM_W-1:0]              sum;
  logic                          ovf_n, flag_n;

  assign cfg_w = {FNS09, FNS08, FNS07, FNS06, FNS05, FNS04, FNS03,
                  {{(FNS_W-1){1'b0}}, FNS02}};

  // Bit 0 carries the fixed unit weight; the rest come from the shadow set.
  always_comb begin
    wvec    = '0;
    wvec[0] = FNS_W'(1);
    for (int i = 1; i < CODE_W; i++) wvec[i] = w_sh[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_sh <= '1;
      w_sh  <= FIB_W;
    end else if (cfg_load) begin
      en_sh <= en_flag;
      w_sh  <= cfg_w;
    end
  end

  for (genvar g = 0; g < CODE_W; g++) begin : g_term
    decoder_2_7_term #(.FNS_W(FNS_W)) u_term (
      .bit_in (codein[g]),
      .en     (en_sh[g]),
      .weight (wvec[g]),
      .term   (terms[g]),
      .viol   (viol[g])
    );
  end

  always_comb begin
    lo_n = '0;
    hi_n = '0;
    for (int i = 0; i < LO_N; i++)      lo_n = lo_n + PS_W'(terms[i]);
    for (int i = LO_N; i < CODE_W; i++) hi_n = hi_n + PS_W'(terms[i]);
  end

  // Stage 1: split partial sums keep each adder tree short.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      psum_lo  <= '0;
      psum_hi  <= '0;
      merr1    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], code_valid};
      if (code_valid) begin
        psum_lo <= lo_n;
        psum_hi <= hi_n;
        merr1   <= |viol;
      end
    end
  end

  assign sum    = SUM_W'(psum_lo) + SUM_W'(psum_hi);
  assign ovf_n  = sum > MAX_VAL;
  assign flag_n = ovf_n | merr1;

  // Stage 2: outputs hold on idle cycles; only data_valid drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dataout   <= '0;
      ovf       <= 1'b0;
      mask_err  <= 1'b0;
      err_count <= '0;
    end else if (vld_pipe[0]) begin
      dataout  <= ovf_n ? '1 : sum[DATA_W-1:0];
      ovf      <= ovf_n;
      mask_err <= merr1;
      if (flag_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign data_valid = vld_pipe[1];
endmodule

// File: tb/tb_decoder_2_7.sv
// Bench for decoder_2_7: directed plan steps plus random traffic, checked against a
// cycle-level model that sums weighted code bits directly.

module tb_decoder_2_7;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_load = 1'b0;
  logic [8:0] en_flag = '1;
  logic       FNS02 = 1'b1;
  logic [7:0] FNS03 = 8'd2, FNS04 = 8'd3, FNS05 = 8'd5, FNS06 = 8'd8;
  logic [7:0] FNS07 = 8'd13, FNS08 = 8'd21, FNS09 = 8'd34;
  logic       code_valid = 1'b0;
  logic [8:0] codein = '0;
  logic       data_valid, ovf, mask_err;
  logic [6:0] dataout;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [8:0] m_en;
  int       m_w [9];
  bit       s1_v, s1_me;
  int       s1_sum;
  bit       m_dv, m_ovf, m_me;
  int       m_do, m_cnt;

  decoder_2_7 dut (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .en_flag(en_flag),
    .FNS02(FNS02), .FNS03(FNS03), .FNS04(FNS04), .FNS05(FNS05), .FNS06(FNS06),
    .FNS07(FNS07), .FNS08(FNS08), .FNS09(FNS09),
    .code_valid(code_valid), .codein(codein),
    .data_valid(data_valid), .dataout(dataout), .ovf(ovf),
    .mask_err(mask_err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = '1;
    m_w  = '{1, 1, 2, 3, 5, 8, 13, 21, 34};
    s1_v = 0; s1_me = 0; s1_sum = 0;
    m_dv = 0; m_ovf = 0; m_me = 0; m_do = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int s;
    m_dv = s1_v;
    if (s1_v) begin
      m_ovf = (s1_sum > 127);
      m_do  = m_ovf ? 127 : s1_sum;
      m_me  = s1_me;
      if ((m_ovf || m_me) && m_cnt < 255) m_cnt++;
    end
    s1_v = code_valid;
    if (code_valid) begin
      s = 0;
      for (int i = 0; i < 9; i++) if (codein[i] && m_en[i]) s += m_w[i];
      s1_sum = s;
      s1_me  = |(codein & ~m_en);
    end
    if (cfg_load) begin
      m_en = en_flag;
      m_w  = '{1, int'(FNS02), int'(FNS03), int'(FNS04), int'(FNS05),
               int'(FNS06), int'(FNS07), int'(FNS08), int'(FNS09)};
    end
  endtask

  task automatic check_all();
    chk("data_valid", data_valid, m_dv);
    chk("dataout",    dataout,    m_do);
    chk("ovf",        ovf,        m_ovf);
    chk("mask_err",   mask_err,   m_me);
    chk("err_count",  err_count,  m_cnt);
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle();
    code_valid = 0; cfg_load = 0;
  endtask

  task automatic send(input logic [8:0] c);
    code_valid = 1; codein = c;
    tick();
    idle();
    tick();
  endtask

  initial begin
    model_reset();
    // Reset state
    @(negedge clock); reset = 1; #1;
    chk("rst_valid", data_valid, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_errcnt", err_count, 0);
    tick(); reset = 0;
    tick();

    // 1: default weights, bits 0 and 8
    send(9'h101);
    chk("t1_valid", data_valid, 1);
    chk("t1_dataout", dataout, 35);
    chk("t1_ovf", ovf, 0);
    chk("t1_merr", mask_err, 0);

    // 2: all bits set, then idle holds
    send(9'h1FF);
    chk("t2_dataout", dataout, 88);
    chk("t2_ovf", ovf, 0);
    tick();
    chk("t2_idle_valid", data_valid, 0);
    chk("t2_hold", dataout, 88);

    // 3: bit 3 disabled
    cfg_load = 1; en_flag = 9'h1F7; tick(); idle();
    send(9'h008);
    chk("t3_dataout", dataout, 0);
    chk("t3_merr", mask_err, 1);
    chk("t3_errcnt", err_count, 1);

    // 4: config and word in the same cycle
    cfg_load = 1; FNS09 = 8'd200; code_valid = 1; codein = 9'h100; tick();
    cfg_load = 0; tick();
    chk("t4_old_w", dataout, 34);
    idle(); tick();
    chk("t4_ovf", ovf, 1);
    chk("t4_sat_out", dataout, 127);
    chk("t4_errcnt", err_count, 2);

    // Random traffic with occasional reconfiguration
    for (int n = 0; n < 250; n++) begin
      code_valid = ($urandom_range(0, 3) != 0);
      codein     = 9'($urandom);
      cfg_load   = ($urandom_range(0, 15) == 0);
      en_flag    = ($urandom_range(0, 1) != 0) ? 9'h1FF : 9'($urandom);
      FNS02 = 1'($urandom);
      FNS03 = 8'($urandom_range(0, 20));  FNS04 = 8'($urandom_range(0, 20));
      FNS05 = 8'($urandom_range(0, 40));  FNS06 = 8'($urandom_range(0, 40));
      FNS07 = 8'($urandom);               FNS08 = 8'($urandom_range(0, 60));
      FNS09 = 8'($urandom);
      tick();
    end
    idle(); tick(); tick();

    // 5: 300 back-to-back flagged words, counter saturates
    cfg_load = 1; en_flag = 9'h1F7; tick(); idle();
    codein = 9'h008; code_valid = 1;
    for (int n = 0; n < 300; n++) tick();
    idle(); tick();
    chk("t5_last_valid", data_valid, 1);
    tick();
    chk("t5_drain", data_valid, 0);
    chk("t5_errcnt", err_count, 255);

    // 6: reset with words in flight
    code_valid = 1; codein = 9'h101; tick();
    codein = 9'h1FF; #2; reset = 1; model_reset();
    @(negedge clock); idle(); reset = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t6_no_valid", data_valid, 0);
    end
    chk("t6_errcnt", err_count, 0);
    send(9'h101);
    chk("t6_default_w", dataout, 35);
    chk("t6_valid", data_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
